// File: rtl/write_controller.sv
// Receive-side loader for the image BRAM: streams DEPTH bytes from the UART
// receiver into port A, then pulses write_done (or write_error on a stall).
module write_controller #(
  parameter int M_STATE = 0,
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 100_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        master_state,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [7:0]        dina,
  output logic [ADDR_W:0]   bytes_written,
  output logic              write_done,
  output logic              write_error,
  output logic [2:0]        status
);

  localparam int TIMER_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0]         ARM_STATE  = 2'(M_STATE);
  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(DEPTH - 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_BYTE = 3'd1,
    WRITE     = 3'd2,
    DONE      = 3'd3,
    ERROR     = 3'd4,
    HOLD      = 3'd5
  } state_t;

  state_t state;
  state_t next_state;

  logic [1:0]         master_state_r;
  logic               rx_ready_r;
  logic [7:0]         rx_data_r;
  logic               pending;
  logic [7:0]         hold_data;
  logic [TIMER_W-1:0] timer;

  logic armed;
  logic byte_avail;
  logic timer_expired;

  assign armed         = (master_state_r == ARM_STATE);
  assign byte_avail    = rx_ready_r | pending;
  assign timer_expired = (bytes_written != '0) && (timer == TIMER_LAST);

  // Input stage is a plain sampler so it already tracks the live inputs when reset releases.
  always_ff @(posedge clk) begin
    master_state_r <= master_state;
    rx_ready_r     <= rx_ready;
    rx_data_r      <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (armed) begin
          next_state = WAIT_BYTE;
        end
      end
      WAIT_BYTE: begin
        if (byte_avail) begin
          next_state = WRITE;
        end else if (timer_expired) begin
          next_state = ERROR;
        end
      end
      WRITE: begin
        next_state = (addra == LAST_ADDR) ? DONE : WAIT_BYTE;
      end
      DONE:    next_state = HOLD;
      ERROR:   next_state = HOLD;
      HOLD: begin
        if (!armed) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ena         = (state == WRITE);
    wea         = (state == WRITE);
    write_done  = (state == DONE);
    write_error = (state == ERROR);
    status      = state;
  end

  // A pending byte is older than one arriving the same cycle, so it is written first
  // and the newcomer takes its place in the holding register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addra         <= '0;
      dina          <= '0;
      bytes_written <= '0;
      pending       <= 1'b0;
      hold_data     <= '0;
      timer         <= '0;
    end else begin
      case (state)
        IDLE: begin
          addra         <= '0;
          bytes_written <= '0;
          timer         <= '0;
          pending       <= 1'b0;
        end
        WAIT_BYTE: begin
          if (pending) begin
            dina  <= hold_data;
            timer <= '0;
            if (rx_ready_r) begin
              hold_data <= rx_data_r;
            end else begin
              pending <= 1'b0;
            end
          end else if (rx_ready_r) begin
            dina  <= rx_data_r;
            timer <= '0;
          end else if (bytes_written != '0) begin
            timer <= timer + TIMER_W'(1);
          end
        end
        WRITE: begin
          bytes_written <= bytes_written + (ADDR_W + 1)'(1);
          if (addra != LAST_ADDR) begin
            addra <= addra + ADDR_W'(1);
          end
          if (rx_ready_r) begin
            pending   <= 1'b1;
            hold_data <= rx_data_r;
          end
        end
        DONE, ERROR, HOLD: begin
          pending <= 1'b0;
          timer   <= '0;
        end
        default: begin
          pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_write_controller.sv
// Directed bench for write_controller: discard/latency, back-to-back pending path,
// timeout, reset mid-transfer, full 1024-byte load and post-done overflow.
module tb_write_controller;

  localparam int DEPTH   = 1024;
  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 1000;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        master_state;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              ena;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [7:0]        dina;
  logic [ADDR_W:0]   bytes_written;
  logic              write_done;
  logic              write_error;
  logic [2:0]        status;

  int checks = 0;
  int errors = 0;
  int wea_count = 0;
  int done_count = 0;
  int err_count = 0;

  write_controller #(
    .M_STATE(0),
    .DEPTH(DEPTH),
    .ADDR_W(ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .master_state(master_state),
    .rx_data(rx_data),
    .rx_ready(rx_ready),
    .ena(ena),
    .wea(wea),
    .addra(addra),
    .dina(dina),
    .bytes_written(bytes_written),
    .write_done(write_done),
    .write_error(write_error),
    .status(status)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wea === 1'b1) wea_count++;
    if (write_done === 1'b1) done_count++;
    if (write_error === 1'b1) err_count++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses rx_ready for one cycle and returns two cycles later, where the write should be.
  task automatic applyStimulus(input logic [7:0] data);
    rx_data  = data;
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    step(1);
  endtask

  task automatic sendByte(input logic [7:0] data, input int exp_addr, input int gap);
    applyStimulus(data);
    checkOutput("wea", {31'd0, wea}, 32'd1);
    checkOutput("addra", {22'd0, addra}, exp_addr);
    checkOutput("dina", {24'd0, dina}, {24'd0, data});
    if (gap > 0) step(gap);
  endtask

  task automatic pulseReset();
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
  endtask

  initial begin
    int base_wea;
    int base_done;
    int base_err;
    int n;

    rst          = 1'b0;
    master_state = 2'd2;
    rx_data      = 8'h00;
    rx_ready     = 1'b0;
    step(3);
    $display("[TB] reset state");
    checkOutput("rst_status", {29'd0, status}, 32'd0);
    checkOutput("rst_ena", {31'd0, ena}, 32'd0);
    checkOutput("rst_wea", {31'd0, wea}, 32'd0);
    checkOutput("rst_addra", {22'd0, addra}, 32'd0);
    checkOutput("rst_dina", {24'd0, dina}, 32'd0);
    checkOutput("rst_bytes", {21'd0, bytes_written}, 32'd0);
    checkOutput("rst_done", {31'd0, write_done}, 32'd0);
    checkOutput("rst_error", {31'd0, write_error}, 32'd0);

    $display("[TB] discard while not armed, then latency");
    rst = 1'b1;
    step(2);
    base_wea = wea_count;
    applyStimulus(8'hA5);
    checkOutput("discard_wea", {31'd0, wea}, 32'd0);
    checkOutput("discard_status", {29'd0, status}, 32'd0);
    step(3);
    checkOutput("discard_count", wea_count - base_wea, 32'd0);
    master_state = 2'd0;
    step(2);
    checkOutput("armed_status", {29'd0, status}, 32'd1);
    applyStimulus(8'h3C);
    checkOutput("lat_wea", {31'd0, wea}, 32'd1);
    checkOutput("lat_ena", {31'd0, ena}, 32'd1);
    checkOutput("lat_addra", {22'd0, addra}, 32'd0);
    checkOutput("lat_dina", {24'd0, dina}, 32'h3C);
    checkOutput("lat_status", {29'd0, status}, 32'd2);
    step(1);
    checkOutput("lat_wea_after", {31'd0, wea}, 32'd0);
    checkOutput("lat_bytes", {21'd0, bytes_written}, 32'd1);
    checkOutput("lat_addra_next", {22'd0, addra}, 32'd1);

    $display("[TB] back-to-back bytes");
    pulseReset();
    checkOutput("b2b_status", {29'd0, status}, 32'd1);
    rx_data  = 8'h11;
    rx_ready = 1'b1;
    step(1);
    rx_data  = 8'h22;
    step(1);
    rx_ready = 1'b0;
    checkOutput("b2b_wea0", {31'd0, wea}, 32'd1);
    checkOutput("b2b_addr0", {22'd0, addra}, 32'd0);
    checkOutput("b2b_dina0", {24'd0, dina}, 32'h11);
    step(1);
    checkOutput("b2b_gap_wea", {31'd0, wea}, 32'd0);
    checkOutput("b2b_gap_addra", {22'd0, addra}, 32'd1);
    step(1);
    checkOutput("b2b_wea1", {31'd0, wea}, 32'd1);
    checkOutput("b2b_addr1", {22'd0, addra}, 32'd1);
    checkOutput("b2b_dina1", {24'd0, dina}, 32'h22);
    step(1);
    checkOutput("b2b_bytes", {21'd0, bytes_written}, 32'd2);

    $display("[TB] inter-byte timeout");
    pulseReset();
    base_done = done_count;
    base_err  = err_count;
    for (int i = 0; i < 5; i++) begin
      sendByte(8'(8'h50 + i), i, (i == 4) ? 0 : 20);
    end
    n = 0;
    while (write_error !== 1'b1 && n < 1100) begin
      step(1);
      n++;
    end
    checkOutput("timeout_latency", n, 32'd1001);
    checkOutput("timeout_status", {29'd0, status}, 32'd4);
    checkOutput("timeout_bytes", {21'd0, bytes_written}, 32'd5);
    step(1);
    checkOutput("timeout_pulse_end", {31'd0, write_error}, 32'd0);
    step(5);
    checkOutput("timeout_hold", {29'd0, status}, 32'd5);
    checkOutput("timeout_err_count", err_count - base_err, 32'd1);
    checkOutput("timeout_no_done", done_count - base_done, 32'd0);
    master_state = 2'd1;
    step(2);
    checkOutput("timeout_idle", {29'd0, status}, 32'd0);
    step(1);
    checkOutput("timeout_idle_bytes", {21'd0, bytes_written}, 32'd0);

    $display("[TB] reset mid-transfer");
    master_state = 2'd0;
    step(2);
    checkOutput("mid_armed", {29'd0, status}, 32'd1);
    base_done = done_count;
    base_err  = err_count;
    for (int i = 0; i < 300; i++) begin
      sendByte(8'(i), i, 3);
    end
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    checkOutput("mid_status", {29'd0, status}, 32'd0);
    checkOutput("mid_wea", {31'd0, wea}, 32'd0);
    checkOutput("mid_addra", {22'd0, addra}, 32'd0);
    checkOutput("mid_dina", {24'd0, dina}, 32'd0);
    checkOutput("mid_bytes", {21'd0, bytes_written}, 32'd0);
    step(1);
    sendByte(8'h77, 0, 3);
    checkOutput("mid_no_done", done_count - base_done, 32'd0);
    checkOutput("mid_no_err", err_count - base_err, 32'd0);

    $display("[TB] full load");
    pulseReset();
    base_wea  = wea_count;
    base_done = done_count;
    for (int i = 0; i < DEPTH; i++) begin
      sendByte(8'(i), i, (i == DEPTH - 1) ? 0 : 18);
    end
    step(1);
    checkOutput("full_done", {31'd0, write_done}, 32'd1);
    checkOutput("full_status", {29'd0, status}, 32'd3);
    checkOutput("full_bytes", {21'd0, bytes_written}, 32'd1024);
    checkOutput("full_addra", {22'd0, addra}, 32'd1023);
    checkOutput("full_wea_off", {31'd0, wea}, 32'd0);
    step(1);
    checkOutput("full_done_end", {31'd0, write_done}, 32'd0);
    checkOutput("full_hold", {29'd0, status}, 32'd5);
    checkOutput("full_wea_count", wea_count - base_wea, 32'd1024);
    checkOutput("full_done_count", done_count - base_done, 32'd1);

    $display("[TB] overflow and hold");
    base_wea = wea_count;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(8'(8'hE0 + k));
      checkOutput("ovf_wea", {31'd0, wea}, 32'd0);
      checkOutput("ovf_status", {29'd0, status}, 32'd5);
      step(3);
    end
    checkOutput("ovf_wea_count", wea_count - base_wea, 32'd0);
    checkOutput("ovf_done_count", done_count - base_done, 32'd1);
    master_state = 2'd1;
    step(2);
    checkOutput("ovf_idle", {29'd0, status}, 32'd0);
    step(1);
    checkOutput("ovf_idle_addra", {22'd0, addra}, 32'd0);
    checkOutput("ovf_idle_bytes", {21'd0, bytes_written}, 32'd0);
    master_state = 2'd0;
    step(2);
    checkOutput("rearm_status", {29'd0, status}, 32'd1);
    sendByte(8'h9E, 0, 2);
    checkOutput("rearm_bytes", {21'd0, bytes_written}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/write_controller.md
Name: write_controller

Overview:
Receive-side counterpart of the UART-to-BRAM image path. When the master FSM enters the load state, this block accepts DEPTH bytes from the UART receiver and writes them sequentially into port A of the shared 1024x8 image BRAM. It then pulses write_done so the master FSM advances toward processing and readback. An inter-byte timeout aborts a stalled transfer and reports write_error.

Parameters:
M_STATE, 0, master_state value that arms this block (load state)
DEPTH, 1024, number of bytes per image; last address is DEPTH-1
ADDR_W, 10, BRAM address width; DEPTH <= 2**ADDR_W
TIMEOUT, 100_000_000, max clk cycles between consecutive bytes after the first byte

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous reset, active-low (0 = reset)
master_state  in  2  master FSM state
rx_data  in  8  byte from UART receiver, valid with rx_ready
rx_ready  in  1  one-cycle pulse: new byte on rx_data
ena  out  1  BRAM port A enable
wea  out  1  BRAM port A write enable
addra  out  ADDR_W  BRAM port A address
dina  out  8  BRAM port A write data
bytes_written  out  ADDR_W+1  count of bytes committed this transfer
write_done  out  1  one-cycle pulse: DEPTH bytes written
write_error  out  1  one-cycle pulse: inter-byte timeout
status  out  3  current FSM state encoding (debug)

Behaviour:
- Input registering: master_state, rx_ready and rx_data are registered one stage (master_state_r, rx_ready_r, rx_data_r). The FSM uses only the registered copies.
- Reset (rst=0 at posedge): state=IDLE; ena=wea=0; addra=0; dina=0; bytes_written=0; write_done=write_error=0; pending=0; timeout counter=0. Reset mid-transfer abandons the transfer and produces no done or error pulse.
- States, encoded 0..5: IDLE, WAIT_BYTE, WRITE, DONE, ERROR, HOLD.
- IDLE: addra=0, bytes_written=0, timer=0. If master_state_r==M_STATE, go to WAIT_BYTE. rx_ready pulses seen in IDLE or HOLD are discarded.
- WAIT_BYTE: on rx_ready_r=1 or pending=1, latch the byte into dina, clear pending, clear timer, go to WRITE. Otherwise, if bytes_written>0, the timer increments; when timer==TIMEOUT-1, go to ERROR. Before the first byte there is no timeout.
- WRITE (exactly 1 cycle): ena=wea=1, addra and dina stable. Next cycle bytes_written increments by 1. If addra==DEPTH-1, go to DONE and leave addra unchanged. Otherwise addra increments by 1 and the FSM returns to WAIT_BYTE.
- rx_ready_r=1 while in WRITE sets pending=1 and captures rx_data_r into a holding register. That byte is consumed on the next WAIT_BYTE cycle; no byte is lost.
- ena/wea are 0 in every state other than WRITE.
- DONE: write_done=1 for one cycle, then go to HOLD.
- ERROR: write_error=1 for one cycle, then go to HOLD. bytes_written keeps the partial count.
- HOLD: stay until master_state_r != M_STATE, then go to IDLE. This prevents re-arming while the master has not yet left the load state.
- Latency: rx_ready input at cycle t gives wea=1 in cycle t+2 with that byte on dina.
- Bytes arriving after DEPTH bytes, while in DONE or HOLD, are ignored and never written.
- master_state leaving M_STATE mid-transfer does not abort; only reset or timeout ends a transfer early.
- Address arithmetic is unsigned ADDR_W bits. addra never exceeds DEPTH-1 and never wraps.

Test Plan:
- Full load: set master_state=0, send 1024 rx_ready pulses with rx_data=addr[7:0] spaced 20 cycles apart -> 1024 wea pulses at addra 0..1023 with dina=addra[7:0]; a single write_done pulse 1 cycle after the write to 1023; bytes_written=1024.
- Latency and discard: pulse rx_ready with 0xA5 while master_state=2 -> no wea. Then set master_state=0 and pulse 0x3C at cycle t -> wea=1, addra=0, dina=0x3C at t+2.
- Back-to-back: rx_ready in consecutive cycles carrying 0x11 then 0x22 -> two wea pulses writing 0x11@0 and 0x22@1; no byte lost (pending path).
- Timeout with TIMEOUT=1000: send 5 bytes, then stall -> write_error pulses once ~1000 cycles after the 5th byte; bytes_written=5; no write_done; state HOLD until master_state changes, then IDLE.
- Reset mid-transfer: assert rst=0 for 1 cycle after 300 bytes -> all outputs zero, state IDLE, no pulses. After re-arm, the next byte writes to addra=0.
- Overflow and HOLD: after write_done, send 3 extra bytes with master_state still 0 -> no wea; changing master_state to 1 -> IDLE; a later re-arm restarts at addra=0.
